// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 active-low matrix keypad one column at a time, debounces
//   presses and releases, encodes the key as row*4+col and presents it to the
//   consumer with a valid/ack handshake.
//
// Ports
//   clock        scan clock, all state on the rising edge
//   reset        asynchronous, active-low; clears all state
//   rows_n[3:0]  keypad rows, active-low, asynchronous to clock
//   key_ack      consumer acknowledge (pulse or level)
//   col_drive_n  active-low one-hot column drive
//   key_code     row_index*4 + col_index of the last published key
//   key_valid    new code available, held until acknowledged
//   key_pressed  debounced key-down level
//   overrun      sticky: a key was published while key_valid was pending
module keypad_scanner #(
    parameter int unsigned SCAN_TICKS       = 500,
    parameter int unsigned DEBOUNCE_SAMPLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] rows_n,
    input  logic       key_ack,
    output logic [3:0] col_drive_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_pressed,
    output logic       overrun
);

    localparam int unsigned     TickW    = $clog2(SCAN_TICKS);
    localparam logic [TickW-1:0] TickLast = TickW'(SCAN_TICKS - 1);
    localparam logic [3:0]      DebLast  = 4'(DEBOUNCE_SAMPLES);

    typedef enum logic [1:0] {
        StScan,
        StDebounce,
        StHeld
    } state_e;

    // Lowest-index row that is pulled low; only meaningful when some row is low.
    function automatic logic [1:0] lowest_low_row(input logic [3:0] r);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!r[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

    // Two-flop synchronizer for the asynchronous row inputs.
    logic [3:0]       rs_meta_q, rs_q;

    state_e           state_q, state_d;
    logic [TickW-1:0] tick_q, tick_d;
    logic [1:0]       col_q, col_d;
    logic [3:0]       col_drive_n_q, col_drive_n_d;
    logic [1:0]       cand_row_q, cand_row_d;
    logic [1:0]       cand_col_q, cand_col_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       rel_q, rel_d;
    logic [3:0]       key_code_q, key_code_d;
    logic             key_valid_q, key_valid_d;
    logic             key_pressed_q, key_pressed_d;
    logic             overrun_q, overrun_d;

    logic             sample;
    logic             publish;
    logic [3:0]       cnt_inc;
    logic [3:0]       rel_inc;

    assign sample  = (tick_q == TickLast);
    assign cnt_inc = cnt_q + 4'd1;
    assign rel_inc = rel_q + 4'd1;

    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        cand_row_d    = cand_row_q;
        cand_col_d    = cand_col_q;
        cnt_d         = cnt_q;
        rel_d         = rel_q;
        key_code_d    = key_code_q;
        key_valid_d   = key_valid_q;
        key_pressed_d = key_pressed_q;
        overrun_d     = overrun_q;
        publish       = 1'b0;

        tick_d = sample ? '0 : tick_q + 1'b1;

        case (state_q)
            StScan: begin
                if (sample) begin
                    if (&rs_q) begin
                        col_d = col_q + 2'd1;
                    end else begin
                        // Column is frozen on the candidate until it is resolved.
                        cand_row_d = lowest_low_row(rs_q);
                        cand_col_d = col_q;
                        cnt_d      = 4'd1;
                        rel_d      = 4'd0;
                        if (DEBOUNCE_SAMPLES == 1) begin
                            publish       = 1'b1;
                            key_pressed_d = 1'b1;
                            state_d       = StHeld;
                        end else begin
                            state_d = StDebounce;
                        end
                    end
                end
            end

            StDebounce: begin
                if (sample) begin
                    if (!rs_q[cand_row_q]) begin
                        if (cnt_inc >= DebLast) begin
                            cnt_d         = DebLast;
                            rel_d         = 4'd0;
                            publish       = 1'b1;
                            key_pressed_d = 1'b1;
                            state_d       = StHeld;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        // Bounce: drop the candidate and carry on scanning.
                        state_d = StScan;
                        col_d   = col_q + 2'd1;
                    end
                end
            end

            StHeld: begin
                // Only the captured row is watched; other rows in this column are ignored.
                if (sample) begin
                    if (rs_q[cand_row_q]) begin
                        if (rel_inc >= DebLast) begin
                            rel_d         = 4'd0;
                            key_pressed_d = 1'b0;
                            state_d       = StScan;
                            col_d         = col_q + 2'd1;
                        end else begin
                            rel_d = rel_inc;
                        end
                    end else begin
                        rel_d = 4'd0;
                    end
                end
            end

            default: begin
                state_d = StScan;
            end
        endcase

        // Handshake. A publish wins over an ack in the same cycle, and that ack
        // neither sets nor clears overrun.
        if (publish) begin
            key_code_d  = {cand_row_d, cand_col_d};
            key_valid_d = 1'b1;
            if (key_valid_q && !key_ack) begin
                overrun_d = 1'b1;
            end
        end else if (key_ack && key_valid_q) begin
            key_valid_d = 1'b0;
            overrun_d   = 1'b0;
        end

        col_drive_n_d = ~(4'b0001 << col_d);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rs_meta_q     <= 4'b1111;
            rs_q          <= 4'b1111;
            state_q       <= StScan;
            tick_q        <= '0;
            col_q         <= 2'd0;
            col_drive_n_q <= 4'b1110;
            cand_row_q    <= 2'd0;
            cand_col_q    <= 2'd0;
            cnt_q         <= 4'd0;
            rel_q         <= 4'd0;
            key_code_q    <= 4'd0;
            key_valid_q   <= 1'b0;
            key_pressed_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            rs_meta_q     <= rows_n;
            rs_q          <= rs_meta_q;
            state_q       <= state_d;
            tick_q        <= tick_d;
            col_q         <= col_d;
            col_drive_n_q <= col_drive_n_d;
            cand_row_q    <= cand_row_d;
            cand_col_q    <= cand_col_d;
            cnt_q         <= cnt_d;
            rel_q         <= rel_d;
            key_code_q    <= key_code_d;
            key_valid_q   <= key_valid_d;
            key_pressed_q <= key_pressed_d;
            overrun_q     <= overrun_d;
        end
    end

    assign col_drive_n = col_drive_n_q;
    assign key_code    = key_code_q;
    assign key_valid   = key_valid_q;
    assign key_pressed = key_pressed_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
//   Directed bench for keypad_scanner with SCAN_TICKS=4, DEBOUNCE_SAMPLES=3.
//   A small keypad model pulls a row low when its key is pressed and its
//   column is driven. Samples happen at every 4th rising edge after reset
//   release; the bench counts edges itself to know where they fall.
module tb_keypad_scanner;

    localparam int unsigned ST = 4;
    localparam int unsigned DS = 3;

    logic       clock   = 1'b0;
    logic       reset   = 1'b1;
    logic       key_ack = 1'b0;
    logic [3:0] rows_n;
    logic [3:0] col_drive_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_pressed;
    logic       overrun;

    // key_mat[row*4+col] = 1 while that key is held down.
    logic [15:0] key_mat = '0;
    int unsigned edge_cnt = 0;
    int          n_checks = 0;
    int          n_fail   = 0;

    keypad_scanner #(
        .SCAN_TICKS       (ST),
        .DEBOUNCE_SAMPLES (DS)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .rows_n      (rows_n),
        .key_ack     (key_ack),
        .col_drive_n (col_drive_n),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_pressed (key_pressed),
        .overrun     (overrun)
    );

    always #5 clock = ~clock;

    always_comb begin
        rows_n = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (key_mat[r*4+c] && !col_drive_n[c]) begin
                    rows_n[r] = 1'b0;
                end
            end
        end
    end

    // Rising edges since reset release.
    always @(posedge clock or negedge reset) begin
        if (!reset) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clock);
        key_mat = '0;
        key_ack = 1'b0;
        reset   = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    // Advance to the falling edge just after the n-th next sample edge.
    task automatic wait_sample(input int n);
        repeat (n) begin
            do @(negedge clock); while (edge_cnt % ST != 0);
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp_rot [4];
        exp_rot = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
        #1 reset = 1'b0;
        repeat (2) @(negedge clock);
        n_checks++; if (col_drive_n !== 4'b1110) begin n_fail++; $display("FAIL rst_col: got %b expected 1110", col_drive_n); end
        n_checks++; if (key_code !== 4'h0) begin n_fail++; $display("FAIL rst_code: got %h expected 0", key_code); end
        n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", key_valid); end
        n_checks++; if (key_pressed !== 1'b0) begin n_fail++; $display("FAIL rst_pressed: got %b expected 0", key_pressed); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL rst_overrun: got %b expected 0", overrun); end
        reset = 1'b1;
        repeat (3) @(negedge clock);
        n_checks++; if (col_drive_n !== 4'b1110) begin n_fail++; $display("FAIL rot_pre: got %b expected 1110", col_drive_n); end
        for (int i = 0; i < 4; i++) begin
            wait_sample(1);
            n_checks++; if (col_drive_n !== exp_rot[i]) begin n_fail++; $display("FAIL rot_%0d: got %b expected %b", i, col_drive_n, exp_rot[i]); end
        end
        // Key 13 (row 3, col 1): capture at sample 6, publish at sample 8.
        key_mat[13] = 1'b1;
        wait_sample(4);
        n_checks++; if (key_code !== 4'hd) begin n_fail++; $display("FAIL pre_rst_code: got %h expected d", key_code); end
        n_checks++; if (key_valid !== 1'b1) begin n_fail++; $display("FAIL pre_rst_valid: got %b expected 1", key_valid); end
        // Asynchronous reset away from any clock edge.
        #2 reset = 1'b0;
        #1;
        n_checks++; if (col_drive_n !== 4'b1110) begin n_fail++; $display("FAIL async_col: got %b expected 1110", col_drive_n); end
        n_checks++; if (key_code !== 4'h0) begin n_fail++; $display("FAIL async_code: got %h expected 0", key_code); end
        n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL async_valid: got %b expected 0", key_valid); end
        n_checks++; if (key_pressed !== 1'b0) begin n_fail++; $display("FAIL async_pressed: got %b expected 0", key_pressed); end
        key_mat = '0;
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        n_checks++; if (col_drive_n !== 4'b1110) begin n_fail++; $display("FAIL restart_col0: got %b expected 1110", col_drive_n); end
        @(negedge clock);
        n_checks++; if (col_drive_n !== 4'b1101) begin n_fail++; $display("FAIL restart_col1: got %b expected 1101", col_drive_n); end
    endtask

    task automatic test_clean_press();
        do_reset();
        key_mat[9] = 1'b1;  // row 2, col 1
        wait_sample(3);
        n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL press_early_valid: got %b expected 0", key_valid); end
        n_checks++; if (col_drive_n !== 4'b1101) begin n_fail++; $display("FAIL press_frozen_col: got %b expected 1101", col_drive_n); end
        wait_sample(1);
        n_checks++; if (key_code !== 4'h9) begin n_fail++; $display("FAIL press_code: got %h expected 9", key_code); end
        n_checks++; if (key_valid !== 1'b1) begin n_fail++; $display("FAIL press_valid: got %b expected 1", key_valid); end
        n_checks++; if (key_pressed !== 1'b1) begin n_fail++; $display("FAIL press_pressed: got %b expected 1", key_pressed); end
        key_mat = '0;
        wait_sample(2);
        n_checks++; if (key_pressed !== 1'b1) begin n_fail++; $display("FAIL rel_early: got %b expected 1", key_pressed); end
        wait_sample(1);
        n_checks++; if (key_pressed !== 1'b0) begin n_fail++; $display("FAIL rel_pressed: got %b expected 0", key_pressed); end
        n_checks++; if (col_drive_n !== 4'b1011) begin n_fail++; $display("FAIL rel_col: got %b expected 1011", col_drive_n); end
        n_checks++; if (key_valid !== 1'b1) begin n_fail++; $display("FAIL rel_valid_held: got %b expected 1", key_valid); end
        key_ack = 1'b1;
        @(negedge clock);
        key_ack = 1'b0;
        n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL ack_valid: got %b expected 0", key_valid); end
        key_ack = 1'b1;
        @(negedge clock);
        key_ack = 1'b0;
        n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL idle_ack_valid: got %b expected 0", key_valid); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL idle_ack_overrun: got %b expected 0", overrun); end
    endtask

    task automatic test_bounce();
        do_reset();
        key_mat[3] = 1'b1;  // row 0, col 3: captured at sample 4
        wait_sample(5);
        n_checks++; if (col_drive_n !== 4'b0111) begin n_fail++; $display("FAIL bounce_frozen: got %b expected 0111", col_drive_n); end
        n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL bounce_valid0: got %b expected 0", key_valid); end
        key_mat = '0;
        wait_sample(1);
        n_checks++; if (col_drive_n !== 4'b1110) begin n_fail++; $display("FAIL bounce_col: got %b expected 1110", col_drive_n); end
        n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL bounce_valid1: got %b expected 0", key_valid); end
        n_checks++; if (key_pressed !== 1'b0) begin n_fail++; $display("FAIL bounce_pressed: got %b expected 0", key_pressed); end
        wait_sample(1);
        n_checks++; if (col_drive_n !== 4'b1101) begin n_fail++; $display("FAIL bounce_rescan: got %b expected 1101", col_drive_n); end
    endtask

    task automatic test_multi_key();
        do_reset();
        key_mat[4]  = 1'b1;  // row 1, col 0
        key_mat[12] = 1'b1;  // row 3, col 0
        wait_sample(3);
        n_checks++; if (key_code !== 4'h4) begin n_fail++; $display("FAIL multi_code: got %h expected 4", key_code); end
        n_checks++; if (key_pressed !== 1'b1) begin n_fail++; $display("FAIL multi_pressed: got %b expected 1", key_pressed); end
        key_mat[12] = 1'b0;
        wait_sample(4);
        n_checks++; if (key_pressed !== 1'b1) begin n_fail++; $display("FAIL multi_other_rel: got %b expected 1", key_pressed); end
        n_checks++; if (col_drive_n !== 4'b1110) begin n_fail++; $display("FAIL multi_col: got %b expected 1110", col_drive_n); end
        key_mat[4] = 1'b0;
        wait_sample(3);
        n_checks++; if (key_pressed !== 1'b0) begin n_fail++; $display("FAIL multi_rel: got %b expected 0", key_pressed); end
        n_checks++; if (col_drive_n !== 4'b1101) begin n_fail++; $display("FAIL multi_rescan: got %b expected 1101", col_drive_n); end
    endtask

    task automatic test_overrun();
        do_reset();
        key_mat[5] = 1'b1;  // row 1, col 1: publish at sample 4
        wait_sample(4);
        n_checks++; if (key_code !== 4'h5) begin n_fail++; $display("FAIL ovr_first_code: got %h expected 5", key_code); end
        key_mat = '0;
        wait_sample(3);
        n_checks++; if (col_drive_n !== 4'b1011) begin n_fail++; $display("FAIL ovr_col: got %b expected 1011", col_drive_n); end
        key_mat[10] = 1'b1;  // row 2, col 2: capture at sample 8, publish at 10
        wait_sample(2);
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_early: got %b expected 0", overrun); end
        wait_sample(1);
        n_checks++; if (key_code !== 4'ha) begin n_fail++; $display("FAIL ovr_code: got %h expected a", key_code); end
        n_checks++; if (key_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid: got %b expected 1", key_valid); end
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b expected 1", overrun); end
        key_ack = 1'b1;
        @(negedge clock);
        key_ack = 1'b0;
        n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_ack_valid: got %b expected 0", key_valid); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_ack_clear: got %b expected 0", overrun); end
    endtask

    task automatic test_ack_collision();
        do_reset();
        key_mat[5] = 1'b1;
        wait_sample(4);
        key_mat = '0;
        wait_sample(3);
        key_mat[7] = 1'b1;  // row 1, col 3: capture at sample 9, publish at edge 44
        while (edge_cnt < 43) @(negedge clock);
        n_checks++; if (key_valid !== 1'b1) begin n_fail++; $display("FAIL coll_pre_valid: got %b expected 1", key_valid); end
        n_checks++; if (key_code !== 4'h5) begin n_fail++; $display("FAIL coll_pre_code: got %h expected 5", key_code); end
        key_ack = 1'b1;
        @(negedge clock);
        key_ack = 1'b0;
        n_checks++; if (key_valid !== 1'b1) begin n_fail++; $display("FAIL coll_valid: got %b expected 1", key_valid); end
        n_checks++; if (key_code !== 4'h7) begin n_fail++; $display("FAIL coll_code: got %h expected 7", key_code); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL coll_overrun: got %b expected 0", overrun); end
        @(negedge clock);
        n_checks++; if (key_valid !== 1'b1) begin n_fail++; $display("FAIL coll_hold: got %b expected 1", key_valid); end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_multi_key();
        test_overrun();
        test_ack_collision();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
